// File: rtl/pipe_issue_sched_if.sv
// Interface bundling the requester handshakes, flush control and the
// pipeline-facing issue bus of pipe_issue_sched.
//   req0_*/req1_*  : instruction requests {func,rd,rs2,rs1,addr} with a ready per requester
//   flush          : stop accepting and drain the scoreboard
//   iss_*          : registered issue strobe and fields toward the pipeline
//   busy_mask      : registers with a pending writeback
//   err_illegal    : one-cycle pulse when an illegal func is dropped
//   issue_cnt      : running count of issued instructions
//   stall_cnt      : hazard stall cycles (only with PIPE_ISSUE_STALL_CNT_EN defined)
// Modports: master = requester/pipeline side, slave = scheduler.
interface pipe_issue_sched_if;
  logic        req0_valid;
  logic [23:0] req0_instr;
  logic        req0_ready;
  logic        req1_valid;
  logic [23:0] req1_instr;
  logic        req1_ready;
  logic        flush;
  logic        iss_valid;
  logic [3:0]  iss_rs1;
  logic [3:0]  iss_rs2;
  logic [3:0]  iss_rd;
  logic [3:0]  iss_func;
  logic [7:0]  iss_addr;
  logic        iss_src;
  logic [15:0] busy_mask;
  logic        err_illegal;
  logic [15:0] issue_cnt;
`ifdef PIPE_ISSUE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  modport master (
    output req0_valid, req0_instr, req1_valid, req1_instr, flush,
    input  req0_ready, req1_ready, iss_valid, iss_rs1, iss_rs2, iss_rd, iss_func,
    input  iss_addr, iss_src, busy_mask, err_illegal,
`ifdef PIPE_ISSUE_STALL_CNT_EN
    input  stall_cnt,
`endif
    input  issue_cnt
  );

  modport slave (
    input  req0_valid, req0_instr, req1_valid, req1_instr, flush,
    output req0_ready, req1_ready, iss_valid, iss_rs1, iss_rs2, iss_rd, iss_func,
    output iss_addr, iss_src, busy_mask, err_illegal,
`ifdef PIPE_ISSUE_STALL_CNT_EN
    output stall_cnt,
`endif
    output issue_cnt
  );
endinterface

// File: rtl/pipe_issue_sched.sv
// Issue scheduler for the 4-stage ALU/regbank/membank pipeline.
// Round-robin arbitration between two requesters, a WB_LAT-deep destination
// scoreboard that stalls RAW hazards (no bypass), registered single-cycle issue.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : pipe_issue_sched_if.slave (requests, flush, issue bus, status)
// Optional: define PIPE_ISSUE_STALL_CNT_EN to add the saturating bus.stall_cnt.
module pipe_issue_sched #(
  parameter int unsigned WB_LAT = 3  // 1..8
) (
  input logic               clk,
  input logic               rst_n,
  pipe_issue_sched_if.slave bus
);

  localparam int unsigned NREQ_W = 1;

  typedef enum logic [0:0] {StRun, StDrain} state_e;

  state_e state_q, state_d;

  logic [23:0]       instr [2];
  logic [1:0]        valid, legal, haz, cand, gnt;
  logic              gnt_any;
  logic [NREQ_W-1:0] gnt_idx;
  logic [NREQ_W-1:0] rr_q;
  logic [23:0]       sel;
  logic              push, drop;

  logic [WB_LAT-1:0] sb_v_q, sb_v_d;
  logic [3:0]        sb_rd_q [WB_LAT];
  logic [3:0]        sb_rd_d [WB_LAT];
  logic              sb_empty;
  logic [15:0]       busy_q, busy_d;

  logic              iss_valid_q, err_q;
  logic [3:0]        iss_rs1_q, iss_rs2_q, iss_rd_q, iss_func_q;
  logic [7:0]        iss_addr_q;
  logic [NREQ_W-1:0] iss_src_q;
  logic [15:0]       cnt_q;

  assign instr[0] = bus.req0_instr;
  assign instr[1] = bus.req1_instr;
  assign valid    = {bus.req1_valid, bus.req0_valid};

  // busy_q always equals the OR of the current valid entries, so it doubles as
  // the pre-shift hazard lookup: a retiring entry still blocks this cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      legal[i] = ~(instr[i][23] & instr[i][22]);
      haz[i]   = legal[i] & (busy_q[instr[i][11:8]] | busy_q[instr[i][15:12]]);
      cand[i]  = valid[i] & (~legal[i] | ~haz[i]);
    end
  end

  assign sb_empty = ~|sb_v_q;

  always_comb begin
    state_d = state_q;
    gnt     = '0;
    unique case (state_q)
      StRun: begin
        if (bus.flush) begin
          state_d = StDrain;
        end else if (&cand) begin
          gnt[rr_q] = 1'b1;
        end else begin
          gnt = cand;
        end
      end
      StDrain: begin
        if (!bus.flush && sb_empty) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  assign gnt_any = |gnt;
  assign gnt_idx = gnt[1];
  assign sel     = instr[gnt_idx];
  assign push    = gnt_any & legal[gnt_idx];
  assign drop    = gnt_any & ~legal[gnt_idx];

  // Scoreboard shifts every cycle; the head takes the new rd on a legal issue.
  always_comb begin
    sb_v_d[0]  = push;
    sb_rd_d[0] = sel[19:16];
    for (int i = 1; i < WB_LAT; i++) begin
      sb_v_d[i]  = sb_v_q[i-1];
      sb_rd_d[i] = sb_rd_q[i-1];
    end
    busy_d = '0;
    for (int i = 0; i < WB_LAT; i++) begin
      if (sb_v_d[i]) busy_d[sb_rd_d[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      rr_q    <= '0;
      sb_v_q  <= '0;
      for (int i = 0; i < WB_LAT; i++) sb_rd_q[i] <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      if (gnt_any) rr_q <= ~gnt_idx;
      sb_v_q  <= sb_v_d;
      sb_rd_q <= sb_rd_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q <= 1'b0;
      err_q       <= 1'b0;
      iss_rs1_q   <= '0;
      iss_rs2_q   <= '0;
      iss_rd_q    <= '0;
      iss_func_q  <= '0;
      iss_addr_q  <= '0;
      iss_src_q   <= '0;
      cnt_q       <= '0;
    end else begin
      iss_valid_q <= push;
      err_q       <= drop;
      // Fields hold their last issued values between issues.
      if (push) begin
        iss_func_q <= sel[23:20];
        iss_rd_q   <= sel[19:16];
        iss_rs2_q  <= sel[15:12];
        iss_rs1_q  <= sel[11:8];
        iss_addr_q <= sel[7:0];
        iss_src_q  <= gnt_idx;
        cnt_q      <= cnt_q + 16'd1;
      end
    end
  end

  assign bus.req0_ready  = gnt[0];
  assign bus.req1_ready  = gnt[1];
  assign bus.iss_valid   = iss_valid_q;
  assign bus.iss_rs1     = iss_rs1_q;
  assign bus.iss_rs2     = iss_rs2_q;
  assign bus.iss_rd      = iss_rd_q;
  assign bus.iss_func    = iss_func_q;
  assign bus.iss_addr    = iss_addr_q;
  assign bus.iss_src     = iss_src_q;
  assign bus.busy_mask   = busy_q;
  assign bus.err_illegal = err_q;
  assign bus.issue_cnt   = cnt_q;

`ifdef PIPE_ISSUE_STALL_CNT_EN
  logic [15:0] stall_cnt_q;
  logic        stall;

  // haz already excludes illegal funcs, so only legal blocked requests count.
  assign stall = (state_q == StRun) && !gnt_any && |(valid & haz);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_issue_sched.sv
module tb_pipe_issue_sched;

  typedef struct packed {
    logic        ill;
    logic        src;
    logic [23:0] ins;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t expq[$];
  logic [15:0] m_cnt = 16'd0;

  pipe_issue_sched_if bus_if ();

  pipe_issue_sched #(.WB_LAT(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [23:0] mk(input logic [3:0] func, input logic [3:0] rd,
                                     input logic [3:0] rs2, input logic [3:0] rs1,
                                     input logic [7:0] addr);
    return {func, rd, rs2, rs1, addr};
  endfunction

  task automatic expect_iss(input logic src, input logic [23:0] ins);
    exp_t e;
    logic ill;
    ill = ins[23] & ins[22];
    if (!ill) m_cnt = m_cnt + 16'd1;
    e.ill = ill;
    e.src = src;
    e.ins = ins;
    e.cnt = m_cnt;
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a request and measure the cycles spent waiting for ready.
  task automatic send(input int idx, input logic [23:0] ins, input int exp_wait,
                      input string name);
    int   w;
    logic rdy;
    w = 0;
    if (idx == 0) begin
      bus_if.req0_valid = 1'b1;
      bus_if.req0_instr = ins;
    end else begin
      bus_if.req1_valid = 1'b1;
      bus_if.req1_instr = ins;
    end
    forever begin
      @(negedge clk);
      rdy = (idx == 0) ? bus_if.req0_ready : bus_if.req1_ready;
      if (rdy) break;
      if (w >= 50) begin
        chk({name, "_timeout"}, 32'(w), 32'(exp_wait));
        break;
      end
      w++;
    end
    @(posedge clk);
    #1;
    if (idx == 0) bus_if.req0_valid = 1'b0;
    else          bus_if.req1_valid = 1'b0;
    chk({name, "_wait"}, 32'(w), 32'(exp_wait));
  endtask

  task automatic do_reset_assert();
    rst_n = 1'b0;
    m_cnt = 16'd0;
    #1;
    chk("rst_iss_valid", 32'(bus_if.iss_valid), 0);
    chk("rst_busy", 32'(bus_if.busy_mask), 0);
    chk("rst_cnt", 32'(bus_if.issue_cnt), 0);
    chk("rst_err", 32'(bus_if.err_illegal), 0);
    chk("rst_fields", 32'({bus_if.iss_rs1, bus_if.iss_rs2, bus_if.iss_rd, bus_if.iss_func,
                           bus_if.iss_addr, bus_if.iss_src}), 0);
  endtask

  // Monitor: pop and compare on every issue strobe or illegal pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus_if.iss_valid || bus_if.err_illegal) begin
        if (expq.size() == 0) begin
          chk("unexpected_output", 32'({bus_if.iss_valid, bus_if.err_illegal}), 0);
        end else begin
          e = expq.pop_front();
          chk("mon_iss_valid", 32'(bus_if.iss_valid), 32'(!e.ill));
          chk("mon_err", 32'(bus_if.err_illegal), 32'(e.ill));
          chk("mon_cnt", 32'(bus_if.issue_cnt), 32'(e.cnt));
          if (!e.ill) begin
            chk("mon_src", 32'(bus_if.iss_src), 32'(e.src));
            chk("mon_fields", 32'({bus_if.iss_func, bus_if.iss_rd, bus_if.iss_rs2,
                                   bus_if.iss_rs1, bus_if.iss_addr}), 32'(e.ins));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [23:0] l0 [2];
    logic [23:0] l1 [2];
    int i0, i1, b10;
    logic r0, r1;

    bus_if.req0_valid = 1'b0;
    bus_if.req0_instr = '0;
    bus_if.req1_valid = 1'b0;
    bus_if.req1_instr = '0;
    bus_if.flush      = 1'b0;

    // Reset state, then a mid-stream asynchronous reset with bit 10 busy.
    do_reset_assert();
    chk("rst_ready", 32'({bus_if.req1_ready, bus_if.req0_ready}), 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    expect_iss(1'b0, mk(4'd0, 4'd10, 4'd4, 4'd5, 8'h10));
    send(0, mk(4'd0, 4'd10, 4'd4, 4'd5, 8'h10), 0, "pre_rst");
    @(negedge clk);
    #2;
    chk("busy_before_rst", 32'(bus_if.busy_mask), 32'h0400);
    do_reset_assert();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_iss(1'b0, mk(4'd0, 4'd2, 4'd1, 4'd3, 8'h33));
    send(0, mk(4'd0, 4'd2, 4'd1, 4'd3, 8'h33), 0, "post_rst");

    // RAW stall: rs1 matches the in-flight rd=10 for three cycles.
    idle(4);
    expect_iss(1'b0, mk(4'd1, 4'd10, 4'd4, 4'd5, 8'h20));
    expect_iss(1'b0, mk(4'd2, 4'd11, 4'd6, 4'd10, 8'h21));
    send(0, mk(4'd1, 4'd10, 4'd4, 4'd5, 8'h20), 0, "raw_prod");
    b10 = 0;
    fork
      send(0, mk(4'd2, 4'd11, 4'd6, 4'd10, 8'h21), 3, "raw_cons");
      begin
        repeat (8) begin
          @(negedge clk);
          if (bus_if.busy_mask[10]) b10++;
        end
      end
    join
    chk("raw_busy10_cycles", 32'(b10), 3);
`ifdef PIPE_ISSUE_STALL_CNT_EN
    chk("stall_after_raw", 32'(bus_if.stall_cnt), 3);
`endif

    // Round robin after a fresh reset: both always valid, independent regs.
    idle(2);
    do_reset_assert();
    idle(1);
    rst_n = 1'b1;
    l0[0] = mk(4'd3, 4'd1, 4'd6, 4'd5, 8'h40);
    l1[0] = mk(4'd4, 4'd2, 4'd8, 4'd7, 8'h41);
    l0[1] = mk(4'd5, 4'd3, 4'd5, 4'd9, 8'h42);
    l1[1] = mk(4'd6, 4'd4, 4'd7, 4'd6, 8'h43);
    expect_iss(1'b0, l0[0]);
    expect_iss(1'b1, l1[0]);
    expect_iss(1'b0, l0[1]);
    expect_iss(1'b1, l1[1]);
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 20 && (i0 < 2 || i1 < 2); c++) begin
      bus_if.req0_valid = (i0 < 2);
      bus_if.req1_valid = (i1 < 2);
      if (i0 < 2) bus_if.req0_instr = l0[i0];
      if (i1 < 2) bus_if.req1_instr = l1[i1];
      @(negedge clk);
      r0 = bus_if.req0_ready;
      r1 = bus_if.req1_ready;
      chk("rr_one_ready", 32'(r0 & r1), 0);
      @(posedge clk);
      #1;
      if (r0) i0++;
      if (r1) i1++;
    end
    bus_if.req0_valid = 1'b0;
    bus_if.req1_valid = 1'b0;
    chk("rr_all_granted", 32'({i0[7:0], i1[7:0]}), 32'h0202);
    chk("rr_issue_cnt", 32'(bus_if.issue_cnt), 4);

    // Preferred req0 stalled on rs2=12; clean req1 goes around it.
    idle(4);
    expect_iss(1'b1, mk(4'd7, 4'd12, 4'd0, 4'd1, 8'h50));
    expect_iss(1'b1, mk(4'd8, 4'd13, 4'd10, 4'd11, 8'h51));
    expect_iss(1'b0, mk(4'd9, 4'd14, 4'd12, 4'd9, 8'h52));
    send(1, mk(4'd7, 4'd12, 4'd0, 4'd1, 8'h50), 0, "byp_prod");
    fork
      send(0, mk(4'd9, 4'd14, 4'd12, 4'd9, 8'h52), 3, "byp_req0");
      send(1, mk(4'd8, 4'd13, 4'd10, 4'd11, 8'h51), 0, "byp_req1");
    join

    // Illegal func is granted despite reading an in-flight reg, and dropped.
    idle(4);
    expect_iss(1'b0, mk(4'd10, 4'd7, 4'd0, 4'd1, 8'h60));
    expect_iss(1'b1, mk(4'd13, 4'd3, 4'd7, 4'd7, 8'h61));
    send(0, mk(4'd10, 4'd7, 4'd0, 4'd1, 8'h60), 0, "ill_prod");
    send(1, mk(4'd13, 4'd3, 4'd7, 4'd7, 8'h61), 0, "ill_req1");
    chk("ill_busy", 32'(bus_if.busy_mask), 32'h0080);
    chk("ill_cnt", 32'(bus_if.issue_cnt), 32'(m_cnt));

    // Flush with two entries in flight; RUN resumes once drained and flush low.
    idle(4);
    expect_iss(1'b0, mk(4'd0, 4'd5, 4'd0, 4'd1, 8'h70));
    expect_iss(1'b1, mk(4'd1, 4'd6, 4'd0, 4'd1, 8'h71));
    expect_iss(1'b0, mk(4'd2, 4'd8, 4'd0, 4'd1, 8'h72));
    send(0, mk(4'd0, 4'd5, 4'd0, 4'd1, 8'h70), 0, "fl_a");
    send(1, mk(4'd1, 4'd6, 4'd0, 4'd1, 8'h71), 0, "fl_b");
    chk("fl_busy", 32'(bus_if.busy_mask), 32'h0060);
    bus_if.flush = 1'b1;
    fork
      send(0, mk(4'd2, 4'd8, 4'd0, 4'd1, 8'h72), 4, "fl_req0");
      begin
        idle(2);
        bus_if.flush = 1'b0;
        idle(1);
        chk("fl_busy_drained", 32'(bus_if.busy_mask), 0);
      end
    join
`ifdef PIPE_ISSUE_STALL_CNT_EN
    chk("stall_final", 32'(bus_if.stall_cnt), 2);
`endif

    idle(6);
    chk("exp_queue_empty", 32'(expq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_issue_sched.md
Name: pipe_issue_sched

Overview:
Issue scheduler in front of the 4-stage ALU/regbank/membank pipeline. Arbitrates two instruction requesters with round-robin fairness. Holds a destination-register scoreboard and stalls any instruction whose rs1/rs2 reads a register still in flight. Drives the pipeline's rs1/rs2/rd/func/addr inputs with a registered, single-cycle issue strobe.

Parameters:
WB_LAT, 3, cycles from issue until the pipeline has written rd into regbank; scoreboard depth (1..8)
NREQ_W, 1, requester index width; fixed at 1 for two requesters, not user-tunable

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an instruction
req0_instr  in  24  {func[23:20], rd[19:16], rs2[15:12], rs1[11:8], addr[7:0]}
req0_ready  out  1  instruction 0 accepted this cycle (combinational)
req1_valid  in  1  requester 1 has an instruction
req1_instr  in  24  same packing as req0_instr
req1_ready  out  1  instruction 1 accepted this cycle
flush  in  1  stop accepting and drain the scoreboard
iss_valid  out  1  issue strobe to the pipeline
iss_rs1, iss_rs2, iss_rd, iss_func  out  4 each  issued fields
iss_addr  out  8  issued membank address
iss_src  out  1  requester index of the issued instruction
busy_mask  out  16  bit r set while regbank[r] has a pending write
err_illegal  out  1  one-cycle pulse when an illegal func (12..15) is dropped
issue_cnt  out  16  total issued instructions, wraps at 65535->0

Behaviour:
- Reset (async, rst_n=0): iss_valid=0, all iss_* fields=0, iss_src=0, busy_mask=0, err_illegal=0, issue_cnt=0, scoreboard cleared, rr pointer=0 (req0 preferred), state=RUN. Reset mid-operation discards all in-flight scoreboard entries immediately.
- Scoreboard: WB_LAT-entry shift register of {v, rd}. The shift happens every cycle. A new entry enters at the head on issue. An entry retires after WB_LAT cycles. busy_mask is the OR of one-hot(rd) over valid entries and is registered.
- Hazard(i) = legal func and (rs1 or rs2 of req i matches rd of any valid entry). No bypass: both operands are always checked, for every func.
- Arbitration (state RUN): the candidate set is requesters with valid=1 and no hazard, plus illegal-func requesters (these never hazard). If both are candidates, grant the rr-preferred one. If only one is a candidate, grant it, even if the other is preferred and stalled. If none, nothing is granted.
- Grant: reqX_ready=1 in the same cycle. At most one ready per cycle. The rr pointer then prefers the other requester.
- Legal grant: next edge gives iss_valid=1, fields from the granted instr, iss_src=X. The scoreboard pushes {1, rd}. issue_cnt increments. Latency is 1 cycle from acceptance to issue.
- Illegal grant: next edge gives err_illegal=1 and iss_valid=0. No scoreboard entry; issue_cnt unchanged.
- iss_valid is 0 on every non-issue cycle. iss_* fields hold their last values.
- Issuing to rd equal to an in-flight rd (WAW) is allowed; the entries are independent.
- States:
  - RUN -> DRAIN when flush=1. The grant in the flush cycle is suppressed: no ready asserted.
  - DRAIN: no readies; the scoreboard continues retiring.
  - DRAIN -> RUN when the scoreboard is empty and flush=0. If flush is still 1, stay in DRAIN.
- Same-cycle retire and hazard: a hazard is evaluated against the scoreboard state before the shift. The retiring entry still blocks for that cycle, which is conservative.
- Requesters must hold valid and instr stable until ready; the scheduler does not check this.

Optional Feature:
Macro PIPE_ISSUE_STALL_CNT_EN.
- Defined: adds output stall_cnt (16 bits, reset 0). It increments each RUN cycle in which at least one valid legal request is blocked by a hazard and no grant occurs. It saturates at 16'hFFFF.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 mid-stream with busy_mask=16'h0400 -> all outputs 0 asynchronously; after release, req0 {func=0, rd=2, rs2=1, rs1=3} issues in 1 cycle.
- RAW stall (WB_LAT=3): req0 issues rd=10. The next cycle req0 has rs1=10 -> ready low for 3 cycles, then issued; busy_mask bit10 set exactly 3 cycles.
- Round robin: both requesters valid every cycle, independent regs -> iss_src sequence 0,1,0,1; issue_cnt=4 after 4 issues.
- Bypass of stalled requester: req0 (preferred) has rs2=12 in flight; req1 is clean -> req1_ready=1, req0 held, req0 issues after retire.
- Illegal func: req1 func=13 -> req1_ready=1, err_illegal pulses once, iss_valid=0, busy_mask unchanged.
- Flush: flush=1 with 2 entries in flight -> no readies, DRAIN until busy_mask=0; flush=0 -> RUN resumes next cycle. With PIPE_ISSUE_STALL_CNT_EN defined, stall_cnt counts only the hazard cycles, not the DRAIN cycles.
